// File: rtl/led_panel_if.sv
// Panel-drive lines seen by the receiver plus the rebuilt row outputs.
interface led_panel_if #(
  parameter int WIDTH    = 8,
  parameter int ROW_BITS = 3
);
  logic                red_in, green_in, blue_in;
  logic                sclk_in, latch_in, aclk_in, arst_in, blank_in;
  logic                row_valid;
  logic [ROW_BITS-1:0] row_addr;
  logic [WIDTH-1:0]    red_row, green_row, blue_row;
  logic                row_overrun, row_short;
  logic                frame_start;
  logic                display_on;

  modport master (
    output red_in, green_in, blue_in, sclk_in, latch_in, aclk_in, arst_in, blank_in,
    input  row_valid, row_addr, red_row, green_row, blue_row,
           row_overrun, row_short, frame_start, display_on
  );

  modport slave (
    input  red_in, green_in, blue_in, sclk_in, latch_in, aclk_in, arst_in, blank_in,
    output row_valid, row_addr, red_row, green_row, blue_row,
           row_overrun, row_short, frame_start, display_on
  );
endinterface

// File: rtl/led_panel_rx.sv
// LED-panel receive monitor: synchronizes the eight drive lines and rebuilds
// each latched RGB row, its row address and row-length error flags.

module led_panel_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             load_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] row_out
);
  logic [WIDTH-1:0] sr;

  // load takes the pre-shift value when both fire together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      row_out <= '0;
    end else begin
      if (shift_en) sr      <= {sr[WIDTH-2:0], bit_in};
      if (load_en)  row_out <= sr;
    end
  end
endmodule

module led_panel_rx #(
  parameter int WIDTH    = 8,
  parameter int ROW_BITS = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  led_panel_if.slave pif
);
  localparam int NUM_LANES = 3;
  localparam int CW        = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] W_C   = CW'(WIDTH);
  localparam logic [CW-1:0] W_MAX = CW'(WIDTH + 1);

  // synchronizer bit positions
  localparam int SC = 3, LA = 4, AC = 5, AR = 6, BL = 7;

  logic [7:0] raw, s1, s2;
  logic [3:0] prev;
  logic       sclk_rise, latch_rise, aclk_rise, arst_fall;

  assign raw = {pif.blank_in, pif.arst_in, pif.aclk_in, pif.latch_in,
                pif.sclk_in, pif.blue_in, pif.green_in, pif.red_in};

  // blank resets high so the panel reads dark out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 8'h80;
      s2   <= 8'h80;
      prev <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      prev <= s2[AR:SC];
    end
  end

  assign sclk_rise  = s2[SC] & ~prev[0];
  assign latch_rise = s2[LA] & ~prev[1];
  assign aclk_rise  = s2[AC] & ~prev[2];
  assign arst_fall  = ~s2[AR] & prev[3];

  logic [NUM_LANES-1:0][WIDTH-1:0] rows;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    led_panel_lane #(.WIDTH(WIDTH)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (sclk_rise),
      .load_en  (latch_rise),
      .bit_in   (s2[l]),
      .row_out  (rows[l])
    );
  end

  assign pif.red_row    = rows[0];
  assign pif.green_row  = rows[1];
  assign pif.blue_row   = rows[2];
  assign pif.display_on = ~s2[BL];

  logic [CW-1:0]       bit_cnt;
  logic [ROW_BITS-1:0] row_cnt, row_addr_q;
  logic                row_valid_q, overrun_q, short_q, frame_start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= '0;
      row_cnt       <= '0;
      row_addr_q    <= '0;
      row_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      short_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      row_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;

      // a shift coinciding with the latch belongs to the next row
      if (latch_rise) begin
        row_valid_q <= 1'b1;
        row_addr_q  <= row_cnt;
        overrun_q   <= (bit_cnt > W_C);
        short_q     <= (bit_cnt < W_C);
        bit_cnt     <= sclk_rise ? CW'(1) : '0;
      end else if (sclk_rise && bit_cnt != W_MAX) begin
        bit_cnt <= bit_cnt + CW'(1);
      end

      if (s2[AR]) begin
        row_cnt <= '0;
      end else if (aclk_rise) begin
        row_cnt <= row_cnt + ROW_BITS'(1);
        if (&row_cnt) frame_start_q <= 1'b1;
      end
      if (arst_fall) frame_start_q <= 1'b1;
    end
  end

  assign pif.row_valid   = row_valid_q;
  assign pif.row_addr    = row_addr_q;
  assign pif.row_overrun = overrun_q;
  assign pif.row_short   = short_q;
  assign pif.frame_start = frame_start_q;
endmodule

// File: tb/tb_led_panel_rx.sv
// Directed bench for led_panel_rx: drives panel waveforms and checks rebuilt rows.
module tb_led_panel_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  led_panel_if #(.WIDTH(8), .ROW_BITS(3)) pif ();

  led_panel_rx #(.WIDTH(8), .ROW_BITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif)
  );

  always #5 clk = ~clk;

  // row/frame pulse monitor
  int         rv_cnt = 0, fs_cnt = 0, rv_double = 0, fs_double = 0;
  logic       rv_prev = 1'b0, fs_prev = 1'b0;
  logic [7:0] cap_red = '0, cap_green = '0, cap_blue = '0;
  logic [2:0] cap_addr = '0;
  logic       cap_over = 1'b0, cap_short = 1'b0;

  always @(negedge clk) begin
    rv_prev <= pif.row_valid;
    fs_prev <= pif.frame_start;
    if (pif.row_valid) begin
      rv_cnt    <= rv_cnt + 1;
      cap_red   <= pif.red_row;
      cap_green <= pif.green_row;
      cap_blue  <= pif.blue_row;
      cap_addr  <= pif.row_addr;
      cap_over  <= pif.row_overrun;
      cap_short <= pif.row_short;
      if (rv_prev) rv_double <= rv_double + 1;
    end
    if (pif.frame_start) begin
      fs_cnt <= fs_cnt + 1;
      if (fs_prev) fs_double <= fs_double + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [15:0] rv, input logic [15:0] gv,
                            input logic [15:0] bv, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      pif.red_in = rv[i]; pif.green_in = gv[i]; pif.blue_in = bv[i];
      cyc(2);
      pif.sclk_in = 1'b1; cyc(3);
      pif.sclk_in = 1'b0; cyc(1);
    end
  endtask

  task automatic pulse_latch();
    pif.latch_in = 1'b1; cyc(3);
    pif.latch_in = 1'b0; cyc(4);
  endtask

  task automatic pulse_aclk();
    pif.aclk_in = 1'b1; cyc(3);
    pif.aclk_in = 1'b0; cyc(3);
  endtask

  task automatic do_row(input logic [15:0] rv, input int n);
    shift_bits(rv, 16'h0000, 16'hFFFF, n);
    pulse_latch();
  endtask

  task automatic test_reset();
    cyc(3);
    n_checks += 6;
    if (pif.row_valid !== 1'b0) begin n_fail++; $display("FAIL reset_row_valid got %b exp 0", pif.row_valid); end
    if ({pif.red_row, pif.green_row, pif.blue_row} !== 24'h0) begin n_fail++; $display("FAIL reset_rows got %h exp 0", {pif.red_row, pif.green_row, pif.blue_row}); end
    if (pif.row_addr !== 3'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", pif.row_addr); end
    if ({pif.row_overrun, pif.row_short} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b exp 00", {pif.row_overrun, pif.row_short}); end
    if (pif.frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start got %b exp 0", pif.frame_start); end
    if (pif.display_on !== 1'b0) begin n_fail++; $display("FAIL reset_display_on got %b exp 0", pif.display_on); end
    rst_n = 1'b1;
    cyc(4);
    n_checks += 2;
    if (pif.display_on !== 1'b1) begin n_fail++; $display("FAIL post_reset_display_on got %b exp 1", pif.display_on); end
    if (rv_cnt !== 0) begin n_fail++; $display("FAIL post_reset_row_valid got %0d rows exp 0", rv_cnt); end
  endtask

  task automatic test_nominal();
    int rv0 = rv_cnt;
    shift_bits(16'h00B2, 16'h0000, 16'h00FF, 8);
    pulse_latch();
    n_checks += 5;
    if (rv_cnt !== rv0 + 1) begin n_fail++; $display("FAIL nominal_row_valid got %0d rows exp 1", rv_cnt - rv0); end
    if ({cap_red, cap_green, cap_blue} !== 24'hB200FF) begin n_fail++; $display("FAIL nominal_data got %h exp B200FF", {cap_red, cap_green, cap_blue}); end
    if (cap_addr !== 3'd0) begin n_fail++; $display("FAIL nominal_addr got %0d exp 0", cap_addr); end
    if ({cap_over, cap_short} !== 2'b00) begin n_fail++; $display("FAIL nominal_flags got %b exp 00", {cap_over, cap_short}); end
    if (pif.row_valid !== 1'b0) begin n_fail++; $display("FAIL nominal_pulse_end got %b exp 0", pif.row_valid); end
  endtask

  task automatic test_rows();
    int fs0 = fs_cnt;
    pif.arst_in = 1'b1; cyc(3);
    pif.arst_in = 1'b0; cyc(5);
    n_checks++;
    if (fs_cnt !== fs0 + 1) begin n_fail++; $display("FAIL arst_frame_start got %0d exp 1", fs_cnt - fs0); end
    repeat (3) pulse_aclk();
    do_row(16'h0011, 8);
    n_checks++;
    if (cap_addr !== 3'd3) begin n_fail++; $display("FAIL row_addr_3 got %0d exp 3", cap_addr); end
    repeat (5) pulse_aclk();
    n_checks++;
    if (fs_cnt !== fs0 + 2) begin n_fail++; $display("FAIL wrap_frame_start got %0d exp 2", fs_cnt - fs0); end
    do_row(16'h0022, 8);
    n_checks++;
    if (cap_addr !== 3'd0) begin n_fail++; $display("FAIL row_addr_wrap got %0d exp 0", cap_addr); end
  endtask

  task automatic test_lengths();
    do_row(16'h0155, 9);
    n_checks += 2;
    if ({cap_over, cap_short} !== 2'b10) begin n_fail++; $display("FAIL len9_flags got %b exp 10", {cap_over, cap_short}); end
    if (cap_red !== 8'h55) begin n_fail++; $display("FAIL len9_data got %h exp 55", cap_red); end
    do_row(16'h0017, 5);
    n_checks += 2;
    if ({cap_over, cap_short} !== 2'b01) begin n_fail++; $display("FAIL len5_flags got %b exp 01", {cap_over, cap_short}); end
    if (cap_red !== 8'hB7) begin n_fail++; $display("FAIL len5_data got %h exp B7", cap_red); end
    do_row(16'h003C, 8);
    n_checks += 2;
    if ({cap_over, cap_short} !== 2'b00) begin n_fail++; $display("FAIL len8_flags got %b exp 00", {cap_over, cap_short}); end
    if (cap_red !== 8'h3C) begin n_fail++; $display("FAIL len8_data got %h exp 3C", cap_red); end
  endtask

  task automatic test_simul();
    int fs0;
    shift_bits(16'h00A5, 16'h0000, 16'hFFFF, 8);
    pif.red_in = 1'b1; cyc(2);
    pif.sclk_in = 1'b1; pif.latch_in = 1'b1; cyc(3);
    pif.sclk_in = 1'b0; pif.latch_in = 1'b0; cyc(4);
    n_checks += 2;
    if (cap_red !== 8'hA5) begin n_fail++; $display("FAIL simul_data got %h exp A5", cap_red); end
    if ({cap_over, cap_short} !== 2'b00) begin n_fail++; $display("FAIL simul_flags got %b exp 00", {cap_over, cap_short}); end
    do_row(16'h000F, 7);
    n_checks += 2;
    if ({cap_over, cap_short} !== 2'b00) begin n_fail++; $display("FAIL simul_next_flags got %b exp 00", {cap_over, cap_short}); end
    if (cap_red !== 8'h8F) begin n_fail++; $display("FAIL simul_next_data got %h exp 8F", cap_red); end
    repeat (2) pulse_aclk();
    fs0 = fs_cnt;
    pif.arst_in = 1'b1;
    repeat (3) pulse_aclk();
    pif.arst_in = 1'b0; cyc(5);
    do_row(16'h0033, 8);
    n_checks += 2;
    if (cap_addr !== 3'd0) begin n_fail++; $display("FAIL arst_hold_addr got %0d exp 0", cap_addr); end
    if (fs_cnt !== fs0 + 1) begin n_fail++; $display("FAIL arst_hold_frame_start got %0d exp 1", fs_cnt - fs0); end
  endtask

  task automatic test_reset_mid();
    int rv0;
    pulse_aclk();
    shift_bits(16'h000F, 16'h0000, 16'hFFFF, 4);
    rst_n = 1'b0; cyc(2);
    n_checks += 3;
    if ({pif.red_row, pif.green_row, pif.blue_row} !== 24'h0) begin n_fail++; $display("FAIL midrst_rows got %h exp 0", {pif.red_row, pif.green_row, pif.blue_row}); end
    if ({pif.row_valid, pif.row_addr, pif.row_overrun, pif.row_short, pif.frame_start} !== 7'h0) begin n_fail++; $display("FAIL midrst_ctrl got %h exp 0", {pif.row_valid, pif.row_addr, pif.row_overrun, pif.row_short, pif.frame_start}); end
    if (pif.display_on !== 1'b0) begin n_fail++; $display("FAIL midrst_display_on got %b exp 0", pif.display_on); end
    rv0 = rv_cnt;
    rst_n = 1'b1; cyc(4);
    n_checks++;
    if (rv_cnt !== rv0) begin n_fail++; $display("FAIL midrst_exit_row_valid got %0d exp 0", rv_cnt - rv0); end
    do_row(16'h0069, 8);
    n_checks += 3;
    if ({cap_over, cap_short} !== 2'b00) begin n_fail++; $display("FAIL midrst_flags got %b exp 00", {cap_over, cap_short}); end
    if (cap_red !== 8'h69) begin n_fail++; $display("FAIL midrst_data got %h exp 69", cap_red); end
    if (cap_addr !== 3'd0) begin n_fail++; $display("FAIL midrst_addr got %0d exp 0", cap_addr); end
  endtask

  task automatic test_blank();
    pif.blank_in = 1'b1; cyc(1);
    n_checks++;
    if (pif.display_on !== 1'b1) begin n_fail++; $display("FAIL blank_early got %b exp 1", pif.display_on); end
    cyc(2);
    n_checks++;
    if (pif.display_on !== 1'b0) begin n_fail++; $display("FAIL blank_off got %b exp 0", pif.display_on); end
    do_row(16'h00C3, 8);
    n_checks++;
    if ({cap_red, cap_blue} !== 16'hC3FF) begin n_fail++; $display("FAIL blank_data got %h exp C3FF", {cap_red, cap_blue}); end
    pif.blank_in = 1'b0; cyc(3);
    n_checks++;
    if (pif.display_on !== 1'b1) begin n_fail++; $display("FAIL blank_on got %b exp 1", pif.display_on); end
  endtask

  task automatic test_pulse_width();
    n_checks += 2;
    if (rv_double !== 0) begin n_fail++; $display("FAIL row_valid_width got %0d long pulses exp 0", rv_double); end
    if (fs_double !== 0) begin n_fail++; $display("FAIL frame_start_width got %0d long pulses exp 0", fs_double); end
  endtask

  initial begin
    pif.red_in = 0; pif.green_in = 0; pif.blue_in = 0;
    pif.sclk_in = 0; pif.latch_in = 0; pif.aclk_in = 0;
    pif.arst_in = 0; pif.blank_in = 0;
    test_reset();
    test_nominal();
    test_rows();
    test_lengths();
    test_simul();
    test_reset_mid();
    test_blank();
    test_pulse_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
